// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode set, instruction field layout and core dimensions
package cpu_pkg;
  localparam int XLEN   = 32;
  localparam int NREG   = 16;
  localparam int RA_W   = 4;
  localparam int IMM_W  = 16;
  localparam int OPC_LO = 28;
  localparam int RD_LO  = 24;
  localparam int RS1_LO = 20;
  localparam int RS2_LO = 16;

  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL,
    OP_ADDI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_JMP, OP_HALT
  } opcode_e;

  typedef enum logic {ST_RUN, ST_HALT} state_e;

  function automatic logic [XLEN-1:0] sext16(input logic [IMM_W-1:0] v);
    return {{(XLEN-IMM_W){v[IMM_W-1]}}, v};
  endfunction
endpackage

// File: rtl/cpu_if.sv
// cpu_if: instruction and data memory bus seen by the core
interface cpu_if;
  logic [31:0] inst_mem_data_i;
  logic [31:0] inst_mem_address_o;
  logic [31:0] data_mem_out_data_i;
  logic [31:0] data_mem_address_o;
  logic [31:0] data_mem_in_data_o;
  logic        data_mem_WE_o;
  modport master (
    input  inst_mem_data_i, data_mem_out_data_i,
    output inst_mem_address_o, data_mem_address_o, data_mem_in_data_o, data_mem_WE_o
  );
  modport slave (
    output inst_mem_data_i, data_mem_out_data_i,
    input  inst_mem_address_o, data_mem_address_o, data_mem_in_data_o, data_mem_WE_o
  );
endinterface

// File: rtl/cpu_regfile.sv
// cpu_regfile: 16x32 registers, two async read ports, one sync write port, r0 hardwired to zero
module cpu_regfile import cpu_pkg::*; (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [RA_W-1:0] i_rs1_addr,
  input  logic [RA_W-1:0] i_rs2_addr,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  input  logic            i_we,
  input  logic [RA_W-1:0] i_rd_addr,
  input  logic [XLEN-1:0] i_rd_data
);
  logic [XLEN-1:0] r_regs [NREG];

  // write port; writes to r0 are dropped so it always reads back zero
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    else if (i_we && i_rd_addr != '0) r_regs[i_rd_addr] <= i_rd_data;

  assign o_rs1_data = (i_rs1_addr == '0) ? '0 : r_regs[i_rs1_addr];
  assign o_rs2_data = (i_rs2_addr == '0) ? '0 : r_regs[i_rs2_addr];
endmodule

// File: rtl/cpu_core.sv
// cpu_core: single-cycle 16-opcode core; decode, ALU, PC and run/halt control
module cpu_core import cpu_pkg::*; (
  input logic CLK,
  input logic RST,
  cpu_if.master bus
);
  logic [XLEN-1:0]  r_pc, w_pc_nxt, w_inst, w_a, w_b, w_imm_sext, w_ea, w_wb_data;
  logic [RA_W-1:0]  w_rd, w_rs1, w_rs2;
  logic [IMM_W-1:0] w_imm;
  opcode_e          w_op;
  state_e           r_state, w_state_nxt;
  logic             w_run, w_taken, w_wb_en;

  assign w_inst     = bus.inst_mem_data_i;
  assign w_op       = opcode_e'(w_inst[OPC_LO +: 4]);
  assign w_rd       = w_inst[RD_LO +: RA_W];
  assign w_rs1      = w_inst[RS1_LO +: RA_W];
  assign w_rs2      = w_inst[RS2_LO +: RA_W];
  assign w_imm      = w_inst[IMM_W-1:0];
  assign w_imm_sext = sext16(w_imm);
  assign w_ea       = w_a + w_imm_sext;
  assign w_run      = (r_state == ST_RUN);

  cpu_regfile u_regfile (
    .i_clk      (CLK),
    .i_rst_n    (RST),
    .i_rs1_addr (w_rs1),
    .i_rs2_addr (w_rs2),
    .o_rs1_data (w_a),
    .o_rs2_data (w_b),
    .i_we       (w_wb_en && w_run),
    .i_rd_addr  (w_rd),
    .i_rd_data  (w_wb_data)
  );

  // writeback value; opcodes without a destination leave w_wb_en low
  always_comb begin
    w_wb_en   = 1'b1;
    w_wb_data = '0;
    case (w_op)
      OP_ADD:  w_wb_data = w_a + w_b;
      OP_SUB:  w_wb_data = w_a - w_b;
      OP_AND:  w_wb_data = w_a & w_b;
      OP_OR:   w_wb_data = w_a | w_b;
      OP_XOR:  w_wb_data = w_a ^ w_b;
      OP_SLL:  w_wb_data = w_a << w_b[4:0];
      OP_SRL:  w_wb_data = w_a >> w_b[4:0];
      OP_ADDI: w_wb_data = w_ea;
      OP_LUI:  w_wb_data = {w_imm, 16'h0};
      OP_LW:   w_wb_data = bus.data_mem_out_data_i;
      default: w_wb_en   = 1'b0;
    endcase
  end

  // next PC and run/halt transition; HALT freezes the PC on its own address
  always_comb begin
    w_taken     = (w_op == OP_BEQ && w_a == w_b) || (w_op == OP_BNE && w_a != w_b);
    w_pc_nxt    = (!w_run || w_op == OP_HALT) ? r_pc :
                  w_taken                     ? r_pc + 32'd1 + w_imm_sext :
                  (w_op == OP_JMP)            ? {16'h0, w_imm} :
                                                r_pc + 32'd1;
    w_state_nxt = (w_run && w_op == OP_HALT) ? ST_HALT : r_state;
  end

  // PC and run/halt state registers
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      r_pc    <= '0;
      r_state <= ST_RUN;
    end else begin
      r_pc    <= w_pc_nxt;
      r_state <= w_state_nxt;
    end

  assign bus.inst_mem_address_o = RST ? r_pc : '0;
  assign bus.data_mem_address_o = w_ea;
  assign bus.data_mem_in_data_o = w_b;
  assign bus.data_mem_WE_o      = RST && w_run && (w_op == OP_SW);
endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: random and directed programs against an instruction-level ISA model, store scoreboard
module tb_cpu_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_if bus();
  cpu_core dut (.CLK(clk), .RST(rst_n), .bus(bus));

  logic [31:0] imem [256];
  logic [31:0] dmem [4096];
  assign bus.inst_mem_data_i     = imem[bus.inst_mem_address_o[7:0]];
  assign bus.data_mem_out_data_i = (bus.data_mem_address_o < 32'd4096) ? dmem[bus.data_mem_address_o[11:0]] : 32'h0;

  typedef struct packed {logic [31:0] addr; logic [31:0] data;} st_t;
  st_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int rd, input int rs1, input int rs2, input int imm);
    return {op[3:0], rd[3:0], rs1[3:0], rs2[3:0], imm[15:0]};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    for (int i = 0; i < 4096; i++) dmem[i] = $urandom;
  endtask

  task automatic step();
    logic we;
    logic [31:0] a, d;
    we = rst_n && bus.data_mem_WE_o;
    a = bus.data_mem_address_o;
    d = bus.data_mem_in_data_o;
    @(posedge clk);
    if (we && a < 32'd4096) dmem[a[11:0]] = d;
    #1;
  endtask

  // architectural interpreter: runs the program to HALT, queues every store it performs
  task automatic model(output logic [31:0] hpc, output int n, output bit ok);
    logic [31:0] r [16];
    logic [31:0] m [4096];
    logic [31:0] pc, ins, a, b, ea, v, sx;
    int op;
    bit wr;
    r = '{default: 32'h0};
    m = dmem;
    pc = 0; n = 0; ok = 0; hpc = 0;
    while (n < 3000) begin
      ins = imem[pc[7:0]];
      op = int'(ins[31:28]);
      a = r[ins[23:20]];
      b = r[ins[19:16]];
      sx = {{16{ins[15]}}, ins[15:0]};
      ea = a + sx;
      wr = 1;
      v = 0;
      case (op)
        1: v = a + b;
        2: v = a - b;
        3: v = a & b;
        4: v = a | b;
        5: v = a ^ b;
        6: v = a << b[4:0];
        7: v = a >> b[4:0];
        8: v = ea;
        9: v = {ins[15:0], 16'h0};
        10: v = (ea < 32'd4096) ? m[ea[11:0]] : 32'h0;
        11: begin
          wr = 0;
          exp_q.push_back({ea, b});
          if (ea < 32'd4096) m[ea[11:0]] = b;
        end
        15: begin
          hpc = pc;
          ok = 1;
          return;
        end
        default: wr = 0;
      endcase
      if ((op == 12 && a == b) || (op == 13 && a != b)) pc = pc + 1 + sx;
      else if (op == 14) pc = {16'h0, ins[15:0]};
      else pc = pc + 1;
      if (wr && ins[27:24] != 4'h0) r[ins[27:24]] = v;
      n++;
    end
    hpc = pc;
  endtask

  task automatic run_prog(input string name);
    logic [31:0] hpc;
    int n;
    bit ok;
    exp_q.delete();
    model(hpc, n, ok);
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s: model found no HALT within budget", name);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk({name, " reset_pc"}, bus.inst_mem_address_o, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (n) step();
    chk({name, " halt_pc"}, bus.inst_mem_address_o, hpc);
    for (int i = 0; i < 10; i++) begin
      step();
      chk({name, " halt_hold"}, bus.inst_mem_address_o, hpc);
    end
    chk({name, " stores_left"}, 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  task automatic monitor();
    st_t e;
    forever begin
      @(negedge clk);
      if (!rst_n && bus.data_mem_WE_o) begin
        checks++;
        failures++;
        $display("FAIL we_in_reset: got 1 expected 0");
      end else if (bus.data_mem_WE_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_store: addr %h data %h, none expected", bus.data_mem_address_o, bus.data_mem_in_data_o);
        end else begin
          e = exp_q.pop_front();
          chk("store_addr", bus.data_mem_address_o, e.addr);
          chk("store_data", bus.data_mem_in_data_o, e.data);
        end
      end
    end
  endtask

  task automatic rand_prog();
    int L, k, t;
    clear_mem();
    L = 24;
    for (int i = 0; i < L; i++) begin
      k = $urandom_range(0, 11);
      t = $urandom_range(0, 3);
      case (k)
        0, 1, 2, 3: imem[i] = enc($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom);
        4, 5: imem[i] = enc(8, $urandom_range(0, 15), $urandom_range(0, 15), 0, $urandom);
        6: imem[i] = enc(9, $urandom_range(0, 15), 0, 0, $urandom);
        7: imem[i] = enc(10, $urandom_range(0, 15), 0, 0, $urandom_range(0, 4095));
        8: imem[i] = enc(11, 0, 0, $urandom_range(0, 15), $urandom_range(0, 4095));
        9: imem[i] = enc(11, 0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom);
        10: imem[i] = enc($urandom_range(12, 13), 0, $urandom_range(0, 3), $urandom_range(0, 3), t);
        default: imem[i] = enc(14, 0, 0, 0, i + 1 + t);
      endcase
    end
    for (int i = 1; i < 16; i++) imem[L + i - 1] = enc(11, 0, 0, i, 300 + i);
    imem[L + 15] = enc(15, 0, 0, 0, 0);
  endtask

  task automatic main_seq();
    // reset holds PC at 0 and suppresses a store sitting at address 0
    clear_mem();
    imem[0] = enc(11, 0, 0, 0, 7);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset_addr", bus.inst_mem_address_o, 32'h0);
      chk("reset_we", {31'h0, bus.data_mem_WE_o}, 32'h0);
    end
    imem[0] = 32'h0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("release_addr", bus.inst_mem_address_o, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("nop_seq", bus.inst_mem_address_o, 32'(i));
    end

    // ALU + store, then image region store
    clear_mem();
    imem[0] = enc(8, 1, 0, 0, 5);
    imem[1] = enc(8, 2, 0, 0, 7);
    imem[2] = enc(1, 3, 1, 2, 0);
    imem[3] = enc(11, 0, 0, 3, 100);
    imem[4] = enc(9, 4, 0, 0, 4);
    imem[5] = enc(11, 0, 4, 3, 0);
    imem[6] = enc(15, 0, 0, 0, 0);
    run_prog("alu_store");

    // load then store back
    clear_mem();
    dmem[10] = 32'hDEADBEEF;
    imem[0] = enc(10, 5, 0, 0, 10);
    imem[1] = enc(11, 0, 0, 5, 11);
    imem[2] = enc(15, 0, 0, 0, 0);
    run_prog("load");

    // countdown loop, body runs three times
    clear_mem();
    imem[0] = enc(8, 1, 0, 0, 3);
    imem[1] = enc(8, 1, 1, 0, -1);
    imem[2] = enc(13, 0, 1, 0, -2);
    imem[3] = enc(11, 0, 0, 1, 50);
    imem[4] = enc(15, 0, 0, 0, 0);
    run_prog("loop");

    // r0 stays zero
    clear_mem();
    imem[0] = enc(8, 0, 0, 0, 9);
    imem[1] = enc(11, 0, 0, 0, 5);
    imem[2] = enc(15, 0, 0, 0, 0);
    run_prog("r0_zero");

    // reset asserted mid-loop forces PC to 0 at once
    clear_mem();
    imem[0] = enc(8, 1, 0, 0, 100);
    imem[1] = enc(8, 1, 1, 0, -1);
    imem[2] = enc(13, 0, 1, 0, -2);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) step();
    chk("midloop_running", {31'h0, bus.inst_mem_address_o != 32'h0}, 32'h1);
    #1 rst_n = 1'b0;
    #1 chk("midloop_reset_pc", bus.inst_mem_address_o, 32'h0);
    step();
    chk("midloop_reset_hold", bus.inst_mem_address_o, 32'h0);

    for (int p = 0; p < 8; p++) begin
      rand_prog();
      run_prog($sformatf("rand%0d", p));
    end
  endtask

  initial begin
    fork
      monitor();
      main_seq();
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_core.md
CPU_CORE -- requirements
Module: cpu_core

Interface
REQ-001 SHALL expose: CLK  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL expose: RST  in  1  asynchronous, active-low reset.
REQ-003 SHALL expose: inst_mem_data_i  in  32  instruction word at inst_mem_address_o, valid before next rising CLK; memory clocks on falling edge.
REQ-004 SHALL expose: inst_mem_address_o  out  32  word address of current instruction (PC).
REQ-005 SHALL expose: data_mem_out_data_i  in  32  load data for data_mem_address_o, valid before next rising CLK.
REQ-006 SHALL expose: data_mem_address_o  out  32  word address for load/store.
REQ-007 SHALL expose: data_mem_in_data_o  out  32  store data.
REQ-008 SHALL expose: data_mem_WE_o  out  1  store strobe, high only during a store cycle.

Function
REQ-009 SHALL be a single-cycle, non-pipelined core: fetch, decode, execute, memory and writeback all within one CLK period; CPI = 1.
REQ-010 SHALL decode fields: opcode[31:28], rd[27:24], rs1[23:20], rs2[19:16], imm[15:0].
REQ-011 SHALL hold 16 x 32-bit registers; r0 reads 0, writes to r0 discarded.
REQ-012 SHALL implement opcodes: 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR; 6 SLL by rs2[4:0]; 7 SRL (logical) by rs2[4:0].
REQ-013 SHALL implement: 8 ADDI rd=rs1+sext(imm); 9 LUI rd={imm,16'h0}; A LW rd=mem[rs1+sext(imm)]; B SW mem[rs1+sext(imm)]=rs2.
REQ-014 SHALL implement: C BEQ and D BNE, comparing rs1 with rs2; taken target PC+1+sext(imm); E JMP PC=zext(imm); F HALT.
REQ-015 SHALL advance PC by 1 (word addressing) for every non-branching instruction and untaken branch.
REQ-016 SHALL compute all arithmetic modulo 2^32; overflow and carry ignored, no flags.
REQ-017 SHALL drive data_mem_address_o = rs1+sext(imm) and data_mem_in_data_o = rs2 combinationally; values undefined but stable when no memory op.
REQ-018 SHALL assert data_mem_WE_o combinationally for exactly the SW cycle only; never during reset or HALT.
REQ-019 SHALL treat data address space as flat 32-bit; 0..4095 is data RAM, addresses >= 262144 are output image; no address checking in core.
REQ-020 SHALL, on HALT, hold PC and all registers until reset; no writes issued.
REQ-021 SHALL treat undefined behaviour as none: every opcode value is defined above.

Reset
REQ-022 SHALL, while RST=0, force PC=0, all registers 0, halted flag 0, asynchronously.
REQ-023 SHALL hold inst_mem_address_o=0 and data_mem_WE_o=0 while RST=0.
REQ-024 SHALL begin executing address 0 at first rising CLK after RST deasserts; reset mid-program aborts current instruction with no register or memory write.

Structure
REQ-025 SHALL place opcode enum, field positions, register count and data width in shared package cpu_pkg.
REQ-026 SHALL implement register file as sub-module cpu_regfile (2 async read ports, 1 sync write port, async active-low reset); remainder (decode, ALU, PC) in cpu_core.

Verification
REQ-027 Reset: RST=0 for 2 cycles then 1 with NOPs -> inst_mem_address_o 0,0,1,2,3; data_mem_WE_o stays 0.
REQ-028 ALU/store: ADDI r1,r0,5; ADDI r2,r0,7; ADD r3,r1,r2; SW r3,100(r0) -> one WE pulse, address 100, data 12.
REQ-029 Image region: LUI r4,4; SW r3,0(r4) with r3=12 -> address 262144, data 12, WE 1 for one cycle.
REQ-030 Load: mem[10]=32'hDEADBEEF; LW r5,10(r0); SW r5,11(r0) -> address 11, data 32'hDEADBEEF.
REQ-031 Loop: ADDI r1,r0,3; at k ADDI r1,r1,-1; at k+1 BNE r1,r0,-2 -> body executes 3 times, then PC=k+2.
REQ-032 Edge cases: ADDI r0,r0,9 then SW r0,5(r0) -> data 0; HALT -> PC constant for 10 cycles, WE 0; RST low mid-loop -> PC=0 immediately.
